// File: rtl/event_injector_pkg.sv
// rtl/event_injector_pkg.sv - shared types and constants for the event injector
package event_injector_pkg;

  localparam int LATE_CNT_W = 8;
  localparam int EV_TS_W    = 32;
  localparam int EV_DATA_W  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FIRE = 2'd2,
    GAP  = 2'd3
  } inj_state_t;

  typedef struct packed {
    logic        [EV_TS_W-1:0]   ts;
    logic signed [EV_DATA_W-1:0] data;
  } event_t;

endpackage

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - single-clock FIFO with a head view that needs no pop
module event_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // storage array; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // pointers and occupancy; full only drops the cycle after a pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/event_injector.sv
// rtl/event_injector.sv - replays timestamped events as monitor strobes; EVENT_INJECTOR_TRACE_EN adds fire_cnt/last_fire_ts
module event_injector
  import event_injector_pkg::*;
#(
  parameter int DATA_W  = EV_DATA_W,
  parameter int TS_W    = EV_TS_W,
  parameter int DEPTH   = 8,
  parameter int MIN_GAP = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     start,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [TS_W-1:0]          s_ts,
  input  logic signed [DATA_W-1:0] s_data,
  output logic signed [DATA_W-1:0] input_0,
  output logic                     new_input_0,
  output logic [TS_W-1:0]          time_now,
  output logic [LATE_CNT_W-1:0]    late_cnt,
  output logic                     order_err,
  output logic                     idle
`ifdef EVENT_INJECTOR_TRACE_EN
  ,
  output logic [31:0]              fire_cnt,
  output logic [TS_W-1:0]          last_fire_ts
`endif
);

  localparam int EV_W = TS_W + DATA_W;
  localparam int GW   = $clog2(MIN_GAP);
  localparam logic [GW-1:0] GAP_LAST = GW'(MIN_GAP - 2);

  inj_state_t        state;
  inj_state_t        next_state;
  logic [GW-1:0]     gap_cnt;
  logic              alive;
  logic [TS_W-1:0]   last_ts;
  logic              strobe_q;
  logic [EV_W-1:0]   head;
  logic [TS_W-1:0]   head_ts;
  logic [DATA_W-1:0] head_data;
  logic              full;
  logic              empty;
  logic              due;
  logic              fire;
  logic              accept;
  logic              order_ok;

  assign s_ready  = en && alive && !full;
  assign accept   = s_valid && s_ready;
  assign order_ok = (s_ts >= last_ts);

  event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept && order_ok),
    .push_data ({s_ts, s_data}),
    .pop       (en && fire),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign head_ts   = head[EV_W-1 -: TS_W];
  assign head_data = head[DATA_W-1:0];
  assign due       = !empty && (time_now >= head_ts);

  // next-state and fire decision; the last GAP cycle may fire directly
  always_comb begin
    next_state = state;
    fire       = 1'b0;
    case (state)
      IDLE: if (start) next_state = WAIT;
      WAIT: begin
        if (due) begin
          fire       = 1'b1;
          next_state = FIRE;
        end
      end
      FIRE: next_state = GAP;
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (due) begin
            fire       = 1'b1;
            next_state = FIRE;
          end else begin
            next_state = WAIT;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // state register and gap length counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else if (en) begin
      state   <= next_state;
      gap_cnt <= (state == GAP && next_state == GAP) ? gap_cnt + GW'(1) : '0;
    end
  end

  // time counter runs once started and sticks at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      time_now <= '0;
    end else if (en && state != IDLE && time_now != '1) begin
      time_now <= time_now + TS_W'(1);
    end
  end

  // push-side bookkeeping: ready release, monotonic timestamp guard
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alive     <= 1'b0;
      last_ts   <= '0;
      order_err <= 1'b0;
    end else if (en) begin
      alive <= 1'b1;
      if (accept && order_ok)  last_ts   <= s_ts;
      if (accept && !order_ok) order_err <= 1'b1;
    end
  end

  // monitor-facing registers, loaded one cycle after the compare
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      strobe_q <= 1'b0;
      input_0  <= '0;
      late_cnt <= '0;
    end else if (en) begin
      strobe_q <= fire;
      input_0  <= fire ? head_data : '0;
      if (fire && time_now > head_ts && late_cnt != '1) late_cnt <= late_cnt + LATE_CNT_W'(1);
    end
  end

  assign new_input_0 = strobe_q && en;
  assign idle        = empty && (state == IDLE || state == WAIT);

`ifdef EVENT_INJECTOR_TRACE_EN
  // strobe count and time of the latest strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fire_cnt     <= '0;
      last_fire_ts <= '0;
    end else if (en && state == FIRE) begin
      fire_cnt     <= fire_cnt + 32'd1;
      last_fire_ts <= time_now;
    end
  end
`endif

endmodule

// File: tb/tb_event_injector.sv
// tb/tb_event_injector.sv - directed and randomized check of event_injector against a time-based model
`timescale 1ns/1ps
module tb_event_injector;
  import event_injector_pkg::*;

  localparam int DATA_W  = 64;
  localparam int TS_W    = 32;
  localparam int DEPTH   = 8;
  localparam int MIN_GAP = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     en = 1'b0;
  logic                     start = 1'b0;
  logic                     s_valid = 1'b0;
  logic                     s_ready;
  logic [TS_W-1:0]          s_ts = '0;
  logic signed [DATA_W-1:0] s_data = '0;
  logic signed [DATA_W-1:0] input_0;
  logic                     new_input_0;
  logic [TS_W-1:0]          time_now;
  logic [7:0]               late_cnt;
  logic                     order_err;
  logic                     idle;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  event_injector #(
    .DATA_W  (DATA_W),
    .TS_W    (TS_W),
    .DEPTH   (DEPTH),
    .MIN_GAP (MIN_GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .start       (start),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_ts        (s_ts),
    .s_data      (s_data),
    .input_0     (input_0),
    .new_input_0 (new_input_0),
    .time_now    (time_now),
    .late_cnt    (late_cnt),
    .order_err   (order_err),
    .idle        (idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // model: accepted events, time, and the time of the last issuing compare
  event_t      mq[$];
  longint      m_last_ts;
  bit          m_order_err;
  bit          m_running;
  longint      m_t;
  int          m_late;
  longint      m_last_c;
  bit          m_strobe;
  logic [63:0] m_data;
  bit          m_alive;

  logic [31:0] log_t[$];
  logic [63:0] log_d[$];
  int          log_c[$];

  function automatic void model_reset();
    mq.delete();
    m_last_ts   = 0;
    m_order_err = 1'b0;
    m_running   = 1'b0;
    m_t         = 0;
    m_late      = 0;
    m_last_c    = -1;
    m_strobe    = 1'b0;
    m_data      = '0;
    m_alive     = 1'b0;
  endfunction

  function automatic void model_step();
    bit     rdy;
    bit     go;
    event_t ev;
    rdy = m_alive && (mq.size() < DEPTH);
    go = m_running && (mq.size() > 0) && (m_t >= longint'(mq[0].ts)) &&
         (m_last_c < 0 || m_t >= m_last_c + MIN_GAP);
    if (go) begin
      m_strobe = 1'b1;
      m_data   = mq[0].data;
      if (m_t > longint'(mq[0].ts) && m_late < 255) m_late++;
      m_last_c = m_t;
      void'(mq.pop_front());
    end else begin
      m_strobe = 1'b0;
      m_data   = '0;
    end
    if (s_valid && rdy) begin
      if (longint'(s_ts) < m_last_ts) begin
        m_order_err = 1'b1;
      end else begin
        ev.ts   = s_ts;
        ev.data = s_data;
        mq.push_back(ev);
        m_last_ts = longint'(s_ts);
      end
    end
    if (!m_running) begin
      if (start) m_running = 1'b1;
    end else if (m_t < longint'(32'hFFFF_FFFF)) begin
      m_t++;
    end
    m_alive = 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else if (en) model_step();
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic compare_all();
    bit exp_ready;
    bit busy;
    bit exp_idle;
    exp_ready = en && m_alive && (mq.size() < DEPTH);
    busy = m_running && (m_last_c >= 0) && (m_t > m_last_c) && (m_t <= m_last_c + MIN_GAP);
    exp_idle = (mq.size() == 0) && !busy;
    check("new_input_0", 64'(new_input_0), 64'(m_strobe & en));
    check("input_0", input_0, m_data);
    check("time_now", 64'(time_now), m_t);
    check("late_cnt", 64'(late_cnt), 64'(m_late));
    check("order_err", 64'(order_err), 64'(m_order_err));
    check("idle", 64'(idle), 64'(exp_idle));
    check("s_ready", 64'(s_ready), 64'(exp_ready));
    if (new_input_0) begin
      log_t.push_back(time_now);
      log_d.push_back(input_0);
      log_c.push_back(cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    en = 1'b1;
    start = 1'b0;
    s_valid = 1'b0;
    run(2);
    rst = 1'b1;
    log_t.delete();
    log_d.delete();
    log_c.delete();
  endtask

  task automatic push_ev(input logic [31:0] ts, input logic [63:0] d);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_ts = ts;
    s_data = d;
    @(negedge clk);
    while (!s_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", 64'(s_ready), 64'd1);
    step();
    s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int n;
    int start_cyc;
    logic [31:0] base;

    en = 1'b1;
    step();
    check("rst_time_now", 64'(time_now), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_new_input_0", 64'(new_input_0), 64'd0);
    fork
      forever begin
        @(negedge clk);
        compare_all();
      end
    join_none

    // reset between strobes
    do_reset();
    push_ev(32'd10, 64'd11);
    push_ev(32'd12, 64'd12);
    push_ev(32'd30, 64'd13);
    pulse_start();
    n = 0;
    while (log_t.size() == 0 && n < 100) begin
      step();
      n++;
    end
    rst = 1'b0;
    #1;
    check("midrst_time_now", 64'(time_now), 64'd0);
    check("midrst_idle", 64'(idle), 64'd1);
    check("midrst_late", 64'(late_cnt), 64'd0);
    run(2);
    rst = 1'b1;
    run(40);
    check("midrst_count", 64'(log_t.size()), 64'd1);
    check("midrst_t0", 64'(log_t[0]), 64'd11);

    // basic schedule
    do_reset();
    push_ev(32'd1000, 64'd1);
    push_ev(32'd1006, 64'd2);
    push_ev(32'd1010, 64'd3);
    pulse_start();
    run(1020);
    check("basic_count", 64'(log_t.size()), 64'd3);
    check("basic_t0", 64'(log_t[0]), 64'd1001);
    check("basic_t1", 64'(log_t[1]), 64'd1007);
    check("basic_t2", 64'(log_t[2]), 64'd1011);
    check("basic_d2", log_d[2], 64'd3);
    check("basic_late", 64'(late_cnt), 64'd0);

    // gap clash
    do_reset();
    push_ev(32'd20, 64'd4);
    push_ev(32'd20, 64'd5);
    push_ev(32'd21, 64'd6);
    pulse_start();
    run(40);
    check("gap_count", 64'(log_t.size()), 64'd3);
    check("gap_t0", 64'(log_t[0]), 64'd21);
    check("gap_t1", 64'(log_t[1]), 64'd23);
    check("gap_t2", 64'(log_t[2]), 64'd25);
    check("gap_d1", log_d[1], 64'd5);
    check("gap_late", 64'(late_cnt), 64'd2);

    // ordering
    do_reset();
    push_ev(32'd50, 64'd7);
    push_ev(32'd40, 64'd8);
    check("order_err", 64'(order_err), 64'd1);
    pulse_start();
    run(70);
    check("order_count", 64'(log_t.size()), 64'd1);
    check("order_t0", 64'(log_t[0]), 64'd51);
    check("order_d0", log_d[0], 64'd7);

    // backpressure
    do_reset();
    for (int i = 0; i < 8; i++) push_ev(32'(100 + i), 64'(i + 1));
    s_valid = 1'b1;
    s_ts = 32'd108;
    s_data = 64'd9;
    step();
    check("bp_full", 64'(s_ready), 64'd0);
    pulse_start();
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("bp_ready_time", 64'(time_now), 64'd101);
    step();
    s_valid = 1'b0;
    run(60);
    check("bp_count", 64'(log_t.size()), 64'd9);
    check("bp_t8", 64'(log_t[8]), 64'd117);
    check("bp_d8", log_d[8], 64'd9);
    check("bp_late", 64'(late_cnt), 64'd8);

    // enable freeze
    do_reset();
    push_ev(32'd100, 64'd9);
    pulse_start();
    start_cyc = cyc;
    run(50);
    en = 1'b0;
    run(5);
    en = 1'b1;
    run(80);
    check("frz_count", 64'(log_t.size()), 64'd1);
    check("frz_t0", 64'(log_t[0]), 64'd101);
    check("frz_cycle", 64'(log_c[0]), 64'(start_cyc + 106));

    // randomized traffic
    for (int r = 0; r < 6; r++) begin
      do_reset();
      base = '0;
      for (int c = 0; c < 250; c++) begin
        en = ($urandom_range(0, 9) != 0);
        start = ($urandom_range(0, 29) == 0) || (c == 40);
        s_valid = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 9) == 0) begin
          s_ts = 32'($urandom_range(0, 60));
        end else begin
          base = base + 32'($urandom_range(0, 6));
          s_ts = base;
        end
        s_data = {$urandom, $urandom};
        step();
      end
      start = 1'b0;
      s_valid = 1'b0;
      en = 1'b1;
      run(20);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
